// File: rtl/icache_pkg.sv
// Shared types and address-field helpers for the direct-mapped instruction cache.
package icache_pkg;

  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_NUM_LINES  = 64;
  localparam int OFF_W = $clog2(DEF_LINE_WORDS);
  localparam int IDX_W = $clog2(DEF_NUM_LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;

  typedef enum logic [1:0] {IDLE, FILL_REQ, FILL_GAP, FILL_DONE} state_e;

  // Field widths are passed in so an overridden cache geometry still splits correctly.
  function automatic logic [31:0] addr_off(input logic [31:0] a, input int off_w);
    return (a >> 2) & ((32'd1 << off_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_idx(input logic [31:0] a, input int off_w, input int idx_w);
    return (a >> (off_w + 2)) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] a, input int off_w, input int idx_w);
    return a >> (off_w + idx_w + 2);
  endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and fill-side signals of the instruction cache; slave is the cache's view.
interface icache_if;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport slave  (input  cpu_req, cpu_addr, flush, mem_rdata, mem_ready,
                  output cpu_rdata, cpu_ready, mem_req, mem_addr);
  modport master (output cpu_req, cpu_addr, flush, mem_rdata, mem_ready,
                  input  cpu_rdata, cpu_ready, mem_req, mem_addr);
endinterface

// File: rtl/icache_line_store.sv
// Tag/valid/data storage: one combinational read port, one write port, clear-all on valid bits.
module icache_line_store
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 64,
  parameter int TAG_W      = 22
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr_all,
  input  logic [$clog2(NUM_LINES)-1:0]  rd_idx,
  input  logic [$clog2(LINE_WORDS)-1:0] rd_off,
  output logic                          rd_valid,
  output logic [TAG_W-1:0]              rd_tag,
  output logic [31:0]                   rd_data,
  input  logic [$clog2(NUM_LINES)-1:0]  wr_idx,
  input  logic [$clog2(LINE_WORDS)-1:0] wr_off,
  input  logic                          data_we,
  input  logic [31:0]                   wr_data,
  input  logic                          tag_we,
  input  logic [TAG_W-1:0]              wr_tag,
  input  logic                          wr_valid
);

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES][LINE_WORDS];

  always_comb begin
    valid_d = valid_q;
    if (tag_we)  valid_d[wr_idx] = wr_valid;
    if (clr_all) valid_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // Contents are don't-care until the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (data_we) data_q[wr_idx][wr_off] <= wr_data;
    if (tag_we)  tag_q[wr_idx] <= wr_tag;
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx][rd_off];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with word-by-word line fill and fence.i flush.
// Define ICACHE_PERF_EN to add the perf_hits / perf_misses counters.
module icache
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 64
) (
  input  logic     clk,
  input  logic     rst_n,
  icache_if.slave  bus
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] perf_hits,
  output logic [31:0] perf_misses
`endif
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam logic [31:0] LINE_MASK = 32'(LINE_WORDS * 4 - 1);

  state_e           state_q, state_d;
  logic [OFF_W-1:0] beat_q, beat_d;
  logic [31:0]      base_q, base_d;
  logic             discard_q, discard_d;

  logic             rd_valid, hit, data_we, tag_we;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_data;

  icache_line_store #(.LINE_WORDS(LINE_WORDS), .NUM_LINES(NUM_LINES), .TAG_W(TAG_W)) u_store (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_all (bus.flush),
    .rd_idx  (IDX_W'(addr_idx(bus.cpu_addr, OFF_W, IDX_W))),
    .rd_off  (OFF_W'(addr_off(bus.cpu_addr, OFF_W))),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .wr_idx  (IDX_W'(addr_idx(base_q, OFF_W, IDX_W))),
    .wr_off  (beat_q),
    .data_we (data_we),
    .wr_data (bus.mem_rdata),
    .tag_we  (tag_we),
    .wr_tag  (TAG_W'(addr_tag(base_q, OFF_W, IDX_W))),
    .wr_valid(!discard_q)
  );

  assign hit = (state_q == IDLE) && bus.cpu_req && rd_valid
            && (rd_tag == TAG_W'(addr_tag(bus.cpu_addr, OFF_W, IDX_W)));

  assign bus.cpu_ready = hit;
  assign bus.cpu_rdata = hit ? rd_data : 32'd0;
  assign bus.mem_req   = (state_q == FILL_REQ);
  assign bus.mem_addr  = base_q + {{(30-OFF_W){1'b0}}, beat_q, 2'b00};

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    base_d    = base_q;
    discard_d = discard_q;
    data_we   = 1'b0;
    tag_we    = 1'b0;
    if (bus.flush && state_q != IDLE) discard_d = 1'b1;
    case (state_q)
      IDLE: if (bus.cpu_req && !hit) begin
        base_d  = bus.cpu_addr & ~LINE_MASK;
        beat_d  = '0;
        state_d = FILL_REQ;
      end
      FILL_REQ: if (bus.mem_ready) begin
        data_we = 1'b1;
        state_d = FILL_GAP;
      end
      // mem_req low for one cycle so the responder can drop its stale ready.
      FILL_GAP: begin
        if (beat_q == OFF_W'(LINE_WORDS - 1)) state_d = FILL_DONE;
        else begin
          beat_d  = beat_q + OFF_W'(1);
          state_d = FILL_REQ;
        end
      end
      FILL_DONE: begin
        tag_we    = 1'b1;
        discard_d = 1'b0;
        beat_d    = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      base_q    <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      base_q    <= base_d;
      discard_q <= discard_d;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hits_q, hits_d, misses_q, misses_d;

  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    if (hit) hits_d = hits_q + 32'd1;
    if (state_q == IDLE && bus.cpu_req && !hit) misses_d = misses_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
    end
  end

  assign perf_hits   = hits_q;
  assign perf_misses = misses_q;
`endif

endmodule
